dtw_result_packer: RTL and testbench
====================================

Name: dtw_result_packer

Overview:
Downstream companion of the DTW search core. It turns host job requests (a read ID) into an rs start pulse for the core and detects completion on the core's done edge. It captures best_score/best_position, buffers each result with its read ID in a small FIFO, and streams it out as a 2-beat 32-bit AXI-Stream packet to the result DMA. It also owns the rs handshake, so the core never restarts before the host has its result.

Parameters:
WORD_LEN, 16, width of core best_score
ID_WIDTH, 16, width of read ID; ID_WIDTH + WORD_LEN <= 32 (elaboration error otherwise)
FIFO_DEPTH, 4, result entries buffered; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
job_valid  in  1  host offers a read ID
job_ready  out  1  job accepted this cycle when job_valid && job_ready
job_id  in  ID_WIDTH  read ID tagged onto the result
rs  out  1  run/stop to core
core_running  in  1  core running flag
core_done  in  1  core done (level, held until next run starts)
core_best_score  in  WORD_LEN  core result score
core_best_position  in  32  core result position
m_axis_tdata  out  32  result beat
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last beat of packet
busy  out  1  job in flight (FSM not IDLE)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (rst=1 at posedge): FSM->IDLE; FIFO emptied; beat pointer->0. Outputs: rs=0, job_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, fifo_count=0. Mid-packet reset drops the packet with no tlast; the core is not reset by this block.
- FSM states: IDLE, START, WAIT_DONE, CAPTURE.
- IDLE:
  - job_ready=1 iff fifo_count < FIFO_DEPTH and core_running=0.
  - On accept: latch job_id, go to START, register rs=1 next cycle.
- START:
  - rs held 1 until core_running sampled 1, then rs<=0 and go to WAIT_DONE.
  - Stale core_done=1 from the previous run is ignored here.
- WAIT_DONE:
  - Capture on the rising edge of core_done (core_done && !done_q, where done_q is the registered core_done). Score/position are sampled in that same cycle.
  - Go to CAPTURE.
- CAPTURE: push {id, score, position} into the FIFO (1 cycle), then IDLE.
- Job to rs latency: 1 cycle. done edge to m_axis_tvalid with an empty FIFO and idle output: 3 cycles (edge detect, CAPTURE push, output register).
- Overflow is impossible: at most one job is in flight and a slot is reserved at accept. Push and pop in the same cycle leave fifo_count unchanged.
- Output packet, head entry:
  - beat0 = {zero-padded job_id in [31:WORD_LEN], best_score in [WORD_LEN-1:0]}, tlast=0.
  - beat1 = best_position, tlast=1.
  - Entry popped on the beat1 handshake.
  - tdata/tvalid/tlast stay stable while tvalid && !tready.
- No combinational path from m_axis_tready to m_axis_tvalid.
- busy = (state != IDLE).

Optional Feature:
Macro DTW_RESULT_CYCLE_COUNT_EN.
- Defined:
  - A 32-bit saturating counter clears on job accept and increments every cycle until the done edge.
  - Its value is stored per FIFO entry.
  - The packet becomes 3 beats: beat2 = cycle count, tlast moves to beat2, and the pop happens on the beat2 handshake.
- Undefined: 2-beat packet, no counter logic.

Decomposition:
- dtw_pkg holds:
  - FSM state encoding (2 bits).
  - RESULT_BEATS constant (2, or 3 under the macro).
  - Beat-field offsets.
  - Entry width ID_WIDTH+WORD_LEN+32(+32).
- One sub-module, dtw_result_fifo: synchronous first-word-fall-through FIFO with parameterised width/depth and count output. The packer's beat mux reads its head.

Test Plan:
- Single job: job_id=0x00A5, core model drives running after rs, done edge with score=0x0123, position=0x0000_1F40 -> one packet: beat0=0x00A5_0123 (tlast=0), then beat1=0x0000_1F40 (tlast=1); rs high exactly until running=1.
- Stale done: core_done held 1 from the prior run when a new job starts -> no capture until done falls (cleared by the core) and rises again; exactly one packet per job.
- Backpressure: tready=0 for 10 cycles after tvalid -> beat0 held stable; beats emitted in order after release, no duplication.
- FIFO fill: 4 jobs completed with tready=0 -> fifo_count=4, job_ready=0 with job_valid=1; after one packet drains -> fifo_count=3, job_ready=1.
- Reset mid-packet: rst asserted after the beat0 handshake -> next cycle tvalid=0, fifo_count=0, busy=0, rs=0; next job produces a clean packet.
- With DTW_RESULT_CYCLE_COUNT_EN: 100 cycles between job accept and done edge -> beat2=0x0000_0064 (tlast=1), beat1 tlast=0.

Source files
------------

// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared types and entry/beat layout for the DTW result packer (macro DTW_RESULT_CYCLE_COUNT_EN)
package dtw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_CAPTURE   = 2'd3
   } dtw_state_e;

`ifdef DTW_RESULT_CYCLE_COUNT_EN
   localparam int RESULT_BEATS = 3;
   localparam int CNT_W        = 32;
`else
   localparam int RESULT_BEATS = 2;
   localparam int CNT_W        = 0;
`endif

   // Entry layout from LSB: [cycle count], position, score, id
   localparam int POS_LSB   = CNT_W;
   localparam int SCORE_LSB = POS_LSB + 32;
   localparam int BEAT_W    = $clog2(RESULT_BEATS);

   function automatic int entry_width(input int id_w, input int word_len);
      return id_w + word_len + 32 + CNT_W;
   endfunction

endpackage

// File: rtl/dtw_result_fifo.sv
// rtl/dtw_result_fifo.sv - synchronous first-word-fall-through result FIFO with occupancy count
module dtw_result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o     = (count_q == '0);
   assign full_o      = (count_q == (AW+1)'(DEPTH));
   assign do_push     = push_i && !full_o;
   assign do_pop      = pop_i && !empty_o;
   assign head_data_o = mem_q[rd_ptr_q];
   assign count_o     = count_q;

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keep the count
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: rtl/dtw_result_packer.sv
// rtl/dtw_result_packer.sv - DTW job launcher, result capture and AXI-Stream packer (macro DTW_RESULT_CYCLE_COUNT_EN adds a cycle-count beat)
module dtw_result_packer
   import dtw_pkg::*;
#(
   parameter int WORD_LEN   = 16,
   parameter int ID_WIDTH   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [ID_WIDTH-1:0]           job_id,
   output logic                          rs,
   input  logic                          core_running,
   input  logic                          core_done,
   input  logic [WORD_LEN-1:0]           core_best_score,
   input  logic [31:0]                   core_best_position,
   output logic [31:0]                   m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int ENTRY_W = entry_width(ID_WIDTH, WORD_LEN);
   localparam int ID_LSB  = SCORE_LSB + WORD_LEN;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RESULT_BEATS - 1);

   if (ID_WIDTH + WORD_LEN > 32) begin : g_bad_width
      $error("dtw_result_packer: ID_WIDTH + WORD_LEN must not exceed 32");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dtw_result_packer: FIFO_DEPTH must be a power of two >= 2");
   end

   dtw_state_e            state_q;
   logic                  rs_q, done_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [WORD_LEN-1:0]   score_q;
   logic [31:0]           pos_q;
   logic [ENTRY_W-1:0]    entry, head;
   logic                  fifo_empty, fifo_full, push, pop, accept, done_rise;
   logic [BEAT_W-1:0]     beat_q, beat_d, sel_beat;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic [31:0]           tdata_q, tdata_d, beat_word;

   // A slot is always free at accept, so an in-flight job can never overflow the FIFO
   assign job_ready = !rst && (state_q == ST_IDLE) && !fifo_full && !core_running;
   assign accept    = job_valid && job_ready;
   assign done_rise = core_done && !done_q;
   assign push      = (state_q == ST_CAPTURE);
   assign pop       = tvalid_q && m_axis_tready && (beat_q == LAST_BEAT);
   assign rs        = rs_q;
   assign busy      = (state_q != ST_IDLE);

   // Job handshake FSM: launch the core, wait for its fresh done edge, capture the result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rs_q    <= 1'b0;
         done_q  <= 1'b0;
         id_q    <= '0;
         score_q <= '0;
         pos_q   <= '0;
      end else begin
         done_q <= core_done;
         case (state_q)
            ST_IDLE: if (accept) begin
               id_q    <= job_id;
               rs_q    <= 1'b1;
               state_q <= ST_START;
            end
            ST_START: if (core_running) begin
               rs_q    <= 1'b0;
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (done_rise) begin
               score_q <= core_best_score;
               pos_q   <= core_best_position;
               state_q <= ST_CAPTURE;
            end
            ST_CAPTURE: state_q <= ST_IDLE;
            default:    state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DTW_RESULT_CYCLE_COUNT_EN
   logic [31:0] cyc_q, cyc_cap_q, cyc_inc;
   assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

   // Saturating job latency counter, snapshotted on the done edge including that cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q     <= '0;
         cyc_cap_q <= '0;
      end else begin
         if (accept) cyc_q <= '0;
         else if (state_q == ST_START || state_q == ST_WAIT_DONE) cyc_q <= cyc_inc;
         if (state_q == ST_WAIT_DONE && done_rise) cyc_cap_q <= cyc_inc;
      end
   end
`endif

   // Assemble the FIFO entry from the captured result
   always_comb begin
      entry = '0;
      entry[ID_LSB +: ID_WIDTH]    = id_q;
      entry[SCORE_LSB +: WORD_LEN] = score_q;
      entry[POS_LSB +: 32]         = pos_q;
`ifdef DTW_RESULT_CYCLE_COUNT_EN
      entry[31:0]                  = cyc_cap_q;
`endif
   end

   dtw_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (entry),
      .pop_i       (pop),
      .head_data_o (head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .count_o     (fifo_count)
   );

   // Beat mux over the FIFO head: next beat while streaming, beat0 when starting a packet
   always_comb begin
      sel_beat  = tvalid_q ? beat_q + 1'b1 : '0;
      beat_word = '0;
      if (sel_beat == '0) begin
         beat_word[WORD_LEN +: ID_WIDTH] = head[ID_LSB +: ID_WIDTH];
         beat_word[WORD_LEN-1:0]         = head[SCORE_LSB +: WORD_LEN];
      end else if (sel_beat == BEAT_W'(1)) begin
         beat_word = head[POS_LSB +: 32];
      end else begin
         beat_word = head[31:0];
      end
   end

   // Output stage next state; a one-cycle bubble after each packet lets the FIFO head advance
   always_comb begin
      beat_d   = beat_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      if (!tvalid_q || m_axis_tready) begin
         if (tvalid_q && beat_q == LAST_BEAT) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            beat_d   = '0;
         end else if (tvalid_q || !fifo_empty) begin
            tvalid_d = 1'b1;
            beat_d   = sel_beat;
            tdata_d  = beat_word;
            tlast_d  = (sel_beat == LAST_BEAT);
         end
      end
   end

   // Registered stream outputs, so tready never reaches tvalid combinationally
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q   <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else begin
         beat_q   <= beat_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_dtw_result_packer.sv
// tb/tb_dtw_result_packer.sv - directed self-checking bench for dtw_result_packer (macro DTW_RESULT_CYCLE_COUNT_EN adds beat2 checks)
module tb_dtw_result_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_valid;
   logic        job_ready;
   logic [15:0] job_id;
   logic        rs;
   logic        core_running;
   logic        core_done;
   logic [15:0] core_best_score;
   logic [31:0] core_best_position;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;
   logic [2:0]  fifo_count;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   dtw_result_packer #(
      .WORD_LEN   (16),
      .ID_WIDTH   (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .job_valid          (job_valid),
      .job_ready          (job_ready),
      .job_id             (job_id),
      .rs                 (rs),
      .core_running       (core_running),
      .core_done          (core_done),
      .core_best_score    (core_best_score),
      .core_best_position (core_best_position),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tlast       (m_axis_tlast),
      .busy               (busy),
      .fifo_count         (fifo_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_ready;
      int k = 0;
      while (!job_ready && k < 300) begin
         tick;
         k++;
      end
      check("job_ready_wait", job_ready, 1);
   endtask

   // Accept a job, act as the core, and raise done so its edge is sampled n edges after accept
   task automatic run_job(input logic [15:0] id, input logic [15:0] sc, input logic [31:0] pos,
                          input int n, input bit stale);
      int acc;
      wait_ready;
      job_id    = id;
      job_valid = 1'b1;
      tick;
      acc       = cyc;
      job_valid = 1'b0;
      check("rs_after_accept", rs, 1);
      check("busy_after_accept", busy, 1);
      tick;
      check("rs_hold", rs, 1);
      core_running = 1'b1;
      tick;
      check("rs_drop_on_running", rs, 0);
      if (stale) begin
         tick;
         tick;
         check("stale_done_ignored", busy, 1);
      end
      core_done = 1'b0;
      while (cyc < acc + n - 1) tick;
      core_running       = 1'b0;
      core_best_score    = sc;
      core_best_position = pos;
      core_done          = 1'b1;
      tick;
   endtask

   task automatic recv_packet(input logic [15:0] id, input logic [15:0] sc, input logic [31:0] pos,
                              input int n);
      int k = 0;
      m_axis_tready = 1'b1;
      while (!m_axis_tvalid && k < 300) begin
         tick;
         k++;
      end
      check("pkt_valid", m_axis_tvalid, 1);
      check("beat0_data", m_axis_tdata, {id, sc});
      check("beat0_last", m_axis_tlast, 0);
      tick;
      check("beat1_valid", m_axis_tvalid, 1);
      check("beat1_data", m_axis_tdata, pos);
`ifdef DTW_RESULT_CYCLE_COUNT_EN
      check("beat1_last", m_axis_tlast, 0);
      tick;
      check("beat2_valid", m_axis_tvalid, 1);
      check("beat2_data", m_axis_tdata, 32'(n));
      check("beat2_last", m_axis_tlast, 1);
`else
      check("beat1_last", m_axis_tlast, 1);
      if (n < 0) check("n_unused", 0, 1);
`endif
      tick;
      m_axis_tready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      job_valid = 1'b0;
      job_id = '0;
      core_running = 1'b0;
      core_done = 1'b0;
      core_best_score = '0;
      core_best_position = '0;
      m_axis_tready = 1'b0;
      tick;
      tick;
      check("rst_rs", rs, 0);
      check("rst_job_ready", job_ready, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      rst = 1'b0;
      #1;
      check("idle_job_ready", job_ready, 1);

      // Single job with latency check from the done edge
      run_job(16'h00A5, 16'h0123, 32'h0000_1F40, 100, 1'b0);
      tick;
      check("lat_push_count", fifo_count, 1);
      check("lat_not_yet_valid", m_axis_tvalid, 0);
      tick;
      check("lat_valid", m_axis_tvalid, 1);
      recv_packet(16'h00A5, 16'h0123, 32'h0000_1F40, 100);
      check("single_done_valid", m_axis_tvalid, 0);
      check("single_done_count", fifo_count, 0);

      // Backpressure: beat0 held stable for 10 cycles
      run_job(16'h1234, 16'hBEEF, 32'hDEAD_0001, 20, 1'b0);
      tick;
      tick;
      for (int i = 0; i < 10; i++) begin
         tick;
         check("bp_hold_valid", m_axis_tvalid, 1);
         check("bp_hold_data", m_axis_tdata, 32'h1234_BEEF);
      end
      recv_packet(16'h1234, 16'hBEEF, 32'hDEAD_0001, 20);
      tick;
      check("bp_no_dup", m_axis_tvalid, 0);

      // Stale done held into WAIT_DONE; exactly one packet
      run_job(16'h0042, 16'h0007, 32'h0000_0099, 30, 1'b1);
      recv_packet(16'h0042, 16'h0007, 32'h0000_0099, 30);
      tick;
      tick;
      check("stale_one_pkt", m_axis_tvalid, 0);
      check("stale_count", fifo_count, 0);

      // FIFO fill with tready low
      for (int j = 0; j < 4; j++)
         run_job(16'(16'h0100 + j), 16'(16'h0010 + j), 32'(32'h0000_5000 + j), 20, 1'b0);
      tick;
      tick;
      check("fill_count", fifo_count, 4);
      job_id    = 16'h0FFF;
      job_valid = 1'b1;
      #1;
      check("fill_not_ready", job_ready, 0);
      recv_packet(16'h0100, 16'h0010, 32'h0000_5000, 20);
      check("drain_count", fifo_count, 3);
      check("drain_ready", job_ready, 1);
      job_valid = 1'b0;
      for (int j = 1; j < 4; j++)
         recv_packet(16'(16'h0100 + j), 16'(16'h0010 + j), 32'(32'h0000_5000 + j), 20);
      tick;
      check("fill_empty", fifo_count, 0);

      // Reset after the beat0 handshake
      run_job(16'h0777, 16'h0555, 32'h0000_0333, 20, 1'b0);
      m_axis_tready = 1'b1;
      for (int k = 0; k < 10 && !m_axis_tvalid; k++) tick;
      check("mr_valid", m_axis_tvalid, 1);
      tick;
      rst = 1'b1;
      m_axis_tready = 1'b0;
      tick;
      check("mr_tvalid", m_axis_tvalid, 0);
      check("mr_tlast", m_axis_tlast, 0);
      check("mr_count", fifo_count, 0);
      check("mr_busy", busy, 0);
      check("mr_rs", rs, 0);
      rst = 1'b0;
      run_job(16'h0888, 16'h0666, 32'h0000_0444, 20, 1'b0);
      recv_packet(16'h0888, 16'h0666, 32'h0000_0444, 20);
      tick;
      check("post_reset_clean", m_axis_tvalid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
